// File: rtl/speed_frame_packer_if.sv
// ============================================================================
// Module   : speed_frame_packer_if
// Purpose  : Byte push bus from the speed frame packer into a TX FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface speed_frame_packer_if #(
    parameter int DATA_SIZE = 8
) ();
    logic                 write;
    logic [DATA_SIZE-1:0] data;
    logic                 fifo_full;

    modport master (
        output write,
        output data,
        input  fifo_full
    );

    modport slave (
        input  write,
        input  data,
        output fifo_full
    );
endinterface

`default_nettype wire

// File: rtl/speed_frame_packer.sv
// ============================================================================
// Module   : speed_frame_packer
// Purpose  : Converts a speed sample to BCD and pushes an 8-byte ASCII frame
//            ('S', 5 digits, XOR checksum, LF) into a TX FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module speed_frame_packer #(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   done,
    input  wire logic [WIDTH_SPEED-1:0] speed,
    speed_frame_packer_if.master        fifo,
    output logic                        busy,
    output logic [7:0]                  drop_count
);

    localparam int                c_cnt_w    = $clog2(WIDTH_SPEED + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH_SPEED);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH_SPEED-1:0] r_shift;
    logic [19:0]            r_bcd;
    logic [19:0]            w_bcd_adj;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_chk;
    logic [7:0]             r_drop;
    logic [7:0]             w_byte;
    logic [DATA_SIZE-1:0]   w_data;
    logic                   w_write;
    logic                   w_conv_last;

    assign w_conv_last = (r_state == S_CONVERT) && (r_cnt == c_cnt_last);
    assign w_write     = (r_state == S_EMIT) && !fifo.fifo_full && !reset;

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < 5; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (done)                       w_state_nxt = S_CONVERT;
            S_CONVERT: if (w_conv_last)                w_state_nxt = S_EMIT;
            S_EMIT:    if (w_write && r_idx == 3'd7)   w_state_nxt = S_IDLE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // After WIDTH_SPEED shifts one more CONVERT cycle registers the checksum,
    // so EMIT only has to select among registered bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_chk   <= '0;
            r_drop  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (done) begin
                        r_shift <= speed;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CONVERT: begin
                    if (r_cnt == c_cnt_last) begin
                        r_chk <= 8'h63 ^ {4'h0, r_bcd[19:16] ^ r_bcd[15:12] ^
                                                r_bcd[11:8]  ^ r_bcd[7:4] ^ r_bcd[3:0]};
                        r_idx <= '0;
                    end else begin
                        {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                        r_cnt            <= r_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_write) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: ;
            endcase

            if (done && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0: w_byte = 8'h53;
            3'd1: w_byte = {4'h3, r_bcd[19:16]};
            3'd2: w_byte = {4'h3, r_bcd[15:12]};
            3'd3: w_byte = {4'h3, r_bcd[11:8]};
            3'd4: w_byte = {4'h3, r_bcd[7:4]};
            3'd5: w_byte = {4'h3, r_bcd[3:0]};
            3'd6: w_byte = r_chk;
            3'd7: w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    assign w_data     = ((r_state == S_EMIT) && !reset) ? DATA_SIZE'(w_byte) : '0;
    assign fifo.write = w_write;
    assign fifo.data  = w_data;
    assign busy       = (r_state != S_IDLE) && !reset;
    assign drop_count = r_drop;

endmodule

`default_nettype wire
